// File: rtl/qspi_tran_seq_pkg.sv
// Shared QSPI sequencer types: phase and lane encodings, phase counter width, length and lane helpers.
package qspi_tran_seq_pkg;

  localparam int CNT_W = 18;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_INST  = 3'd1,
    PH_ADDR  = 3'd2,
    PH_DUMMY = 3'd3,
    PH_WDATA = 3'd4,
    PH_RDATA = 3'd5,
    PH_GAP   = 3'd6
  } phase_e;

  localparam logic [1:0] LANE_X1 = 2'd0;
  localparam logic [1:0] LANE_X2 = 2'd1;
  localparam logic [1:0] LANE_X4 = 2'd2;

  function automatic logic [1:0] lane_sel(input logic spi, input logic dpi);
    return spi ? LANE_X4 : (dpi ? LANE_X2 : LANE_X1);
  endfunction

  // size*burstlen nibbles, scaled by clocks per nibble (x4=1, x2=2, x1=4)
  function automatic logic [CNT_W-1:0] phase_len(input logic [7:0] size, input logic [7:0] burst,
                                                 input logic [1:0] lane);
    logic [CNT_W-1:0] prod;
    prod = CNT_W'(size) * CNT_W'(burst);
    case (lane)
      LANE_X4: return prod;
      LANE_X2: return prod << 1;
      default: return prod << 2;
    endcase
  endfunction

  // Low counter bits that must be zero at a nibble boundary.
  function automatic logic [1:0] nib_mask(input logic [1:0] lane);
    case (lane)
      LANE_X4: return 2'b00;
      LANE_X2: return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  // First enabled phase strictly after cur in INST..RDATA order; GAP when none remain.
  function automatic phase_e next_phase(input phase_e cur, input logic [5:1] act);
    phase_e nxt;
    nxt = PH_GAP;
    for (int i = 5; i >= 1; i--) begin
      if (act[i] && (3'(i) > cur)) nxt = phase_e'(3'(i));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/qspi_tran_seq_phase_cnt.sv
// Shared phase down-counter: load L-1 on phase entry, decrement per unstalled clock, hold otherwise.
// Flags the last SCK of the phase and nibble boundaries for the current lane width.
module qspi_tran_seq_phase_cnt
  import qspi_tran_seq_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  input  logic [1:0]       i_nib_mask,
  output logic             o_last,
  output logic             o_nib_end
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset)                   r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_last    = (r_cnt == '0);
  assign o_nib_end = ((r_cnt[1:0] & i_nib_mask) == 2'b00);

endmodule

// File: rtl/qspi_tran_seq.sv
// QSPI transfer sequencer: pops a buffered request and steps INST->ADDR->DUMMY->DATA, outputs decoded from state;
// io_stall freezes SCK and the phase counter. Stall watchdog enabled by defining QSPI_SEQ_TIMEOUT_EN.
module qspi_tran_seq
  import qspi_tran_seq_pkg::*;
#(
  parameter int CS_GAP  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_start_signal,
  output logic       io_next_req,
  input  logic       io_addr_valid,
  input  logic       io_dummy_valid,
  input  logic       io_wr_valid,
  input  logic       io_rd_valid,
  input  logic       io_erase_valid,
  input  logic [7:0] io_inst_size,
  input  logic [7:0] io_inst_burstlen,
  input  logic [7:0] io_addr_size,
  input  logic [7:0] io_addr_burstlen,
  input  logic [7:0] io_dummy_size,
  input  logic [7:0] io_dummy_burstlen,
  input  logic [7:0] io_data_size,
  input  logic [7:0] io_data_burstlen,
  input  logic       io_addr_mode_en,
  input  logic       io_addr_spi_mode,
  input  logic       io_addr_dpi_mode,
  input  logic       io_data_mode_en,
  input  logic       io_data_spi_mode,
  input  logic       io_data_dpi_mode,
  input  logic       io_tran_spi_mode,
  input  logic       io_tran_dpi_mode,
  input  logic       io_stall,
  output logic       io_cs_n,
  output logic       io_sck_en,
  output logic [2:0] io_phase,
  output logic [1:0] io_lane,
  output logic       io_nibble_strobe,
  output logic       io_phase_last,
  output logic       io_err
);

  localparam int GAP_W = $clog2(CS_GAP + 1);

  phase_e           r_state, w_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [1:0]       w_g_lane, w_a_lane, w_d_lane, w_lane;
  logic [CNT_W-1:0] w_len_inst, w_len_addr, w_len_dummy, w_len_data, w_load_val;
  logic [5:1]       w_act;
  logic             w_wr_eff, w_rd_eff, w_illegal, w_active, w_gap_end, w_accept;
  logic             w_abort, w_load, w_last, w_nib_end;

  assign w_g_lane = lane_sel(io_tran_spi_mode, io_tran_dpi_mode);
  assign w_a_lane = io_addr_mode_en ? lane_sel(io_addr_spi_mode, io_addr_dpi_mode) : w_g_lane;
  assign w_d_lane = io_data_mode_en ? lane_sel(io_data_spi_mode, io_data_dpi_mode) : w_g_lane;

  assign w_len_inst  = phase_len(io_inst_size, io_inst_burstlen, w_g_lane);
  assign w_len_addr  = phase_len(io_addr_size, io_addr_burstlen, w_a_lane);
  assign w_len_dummy = phase_len(io_dummy_size, io_dummy_burstlen, w_g_lane);
  assign w_len_data  = phase_len(io_data_size, io_data_burstlen, w_d_lane);

  // Erase runs INST(+ADDR) only; write wins when both data directions are requested.
  assign w_wr_eff  = io_wr_valid && !io_erase_valid;
  assign w_rd_eff  = io_rd_valid && !io_wr_valid && !io_erase_valid;
  assign w_illegal = (io_wr_valid && io_rd_valid) || (io_erase_valid && (io_wr_valid || io_rd_valid));
  assign w_act     = {w_rd_eff && (w_len_data != '0),
                      w_wr_eff && (w_len_data != '0),
                      io_dummy_valid && !io_erase_valid && (w_len_dummy != '0),
                      io_addr_valid && (w_len_addr != '0),
                      w_len_inst != '0};

  assign w_active  = (r_state == PH_INST) || (r_state == PH_ADDR) || (r_state == PH_DUMMY) ||
                     (r_state == PH_WDATA) || (r_state == PH_RDATA);
  assign w_gap_end = (r_state == PH_GAP) && (r_gap_cnt == GAP_W'(CS_GAP - 1));
  // The last GAP clock may accept the next head directly; with a 1-clock gap the pop is still in flight.
  assign w_accept  = io_start_signal && ((r_state == PH_IDLE) || (w_gap_end && (CS_GAP > 1)));

`ifdef QSPI_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_stall_cnt;

  always_ff @(posedge clock) begin
    if (reset || !w_active || !io_stall) r_stall_cnt <= '0;
    else                                 r_stall_cnt <= r_stall_cnt + TO_W'(1);
  end

  assign w_abort = w_active && io_stall && (r_stall_cnt == TO_W'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= PH_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      PH_IDLE, PH_GAP: begin
        if (w_accept)       w_nxt = next_phase(PH_IDLE, w_act);
        else if (w_gap_end) w_nxt = PH_IDLE;
      end
      default: begin
        if (w_abort)                w_nxt = PH_GAP;
        else if (!io_stall && w_last) w_nxt = next_phase(r_state, w_act);
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || r_state != PH_GAP || w_accept) r_gap_cnt <= '0;
    else if (!w_gap_end)                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
  end

  assign w_load = (w_nxt != r_state) && (w_nxt != PH_IDLE) && (w_nxt != PH_GAP);

  always_comb begin
    w_load_val = '0;
    case (w_nxt)
      PH_INST:            w_load_val = w_len_inst - CNT_W'(1);
      PH_ADDR:            w_load_val = w_len_addr - CNT_W'(1);
      PH_DUMMY:           w_load_val = w_len_dummy - CNT_W'(1);
      PH_WDATA, PH_RDATA: w_load_val = w_len_data - CNT_W'(1);
      default:            w_load_val = '0;
    endcase
  end

  always_comb begin
    w_lane = LANE_X1;
    case (r_state)
      PH_INST, PH_DUMMY:  w_lane = w_g_lane;
      PH_ADDR:            w_lane = w_a_lane;
      PH_WDATA, PH_RDATA: w_lane = w_d_lane;
      default:            w_lane = LANE_X1;
    endcase
  end

  qspi_tran_seq_phase_cnt u_phase_cnt (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_active && !io_stall),
    .i_nib_mask (nib_mask(w_lane)),
    .o_last     (w_last),
    .o_nib_end  (w_nib_end)
  );

  always_comb begin
    io_cs_n          = 1'b1;
    io_sck_en        = 1'b0;
    io_phase         = r_state;
    io_lane          = w_lane;
    io_nibble_strobe = 1'b0;
    io_phase_last    = 1'b0;
    if (w_active) begin
      io_cs_n          = 1'b0;
      io_sck_en        = !io_stall;
      io_phase_last    = w_last;
      io_nibble_strobe = !io_stall && (r_state != PH_DUMMY) && w_nib_end;
    end
    io_next_req = (r_state == PH_GAP) && (r_gap_cnt == '0);
    io_err      = !reset && ((w_accept && w_illegal) || w_abort);
  end

endmodule

// File: tb/tb_qspi_tran_seq.sv
// Self-checking bench for qspi_tran_seq: directed scenarios plus randomized requests against a phase-level model.
module tb_qspi_tran_seq;

  localparam int CS_GAP = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, io_start_signal, io_next_req;
  logic       io_addr_valid, io_dummy_valid, io_wr_valid, io_rd_valid, io_erase_valid;
  logic [7:0] io_inst_size, io_inst_burstlen, io_addr_size, io_addr_burstlen;
  logic [7:0] io_dummy_size, io_dummy_burstlen, io_data_size, io_data_burstlen;
  logic       io_addr_mode_en, io_addr_spi_mode, io_addr_dpi_mode;
  logic       io_data_mode_en, io_data_spi_mode, io_data_dpi_mode;
  logic       io_tran_spi_mode, io_tran_dpi_mode, io_stall;
  logic       io_cs_n, io_sck_en, io_nibble_strobe, io_phase_last, io_err;
  logic [2:0] io_phase;
  logic [1:0] io_lane;

  qspi_tran_seq #(.CS_GAP(CS_GAP), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .io_start_signal(io_start_signal), .io_next_req(io_next_req),
    .io_addr_valid(io_addr_valid), .io_dummy_valid(io_dummy_valid), .io_wr_valid(io_wr_valid),
    .io_rd_valid(io_rd_valid), .io_erase_valid(io_erase_valid),
    .io_inst_size(io_inst_size), .io_inst_burstlen(io_inst_burstlen),
    .io_addr_size(io_addr_size), .io_addr_burstlen(io_addr_burstlen),
    .io_dummy_size(io_dummy_size), .io_dummy_burstlen(io_dummy_burstlen),
    .io_data_size(io_data_size), .io_data_burstlen(io_data_burstlen),
    .io_addr_mode_en(io_addr_mode_en), .io_addr_spi_mode(io_addr_spi_mode), .io_addr_dpi_mode(io_addr_dpi_mode),
    .io_data_mode_en(io_data_mode_en), .io_data_spi_mode(io_data_spi_mode), .io_data_dpi_mode(io_data_dpi_mode),
    .io_tran_spi_mode(io_tran_spi_mode), .io_tran_dpi_mode(io_tran_dpi_mode), .io_stall(io_stall),
    .io_cs_n(io_cs_n), .io_sck_en(io_sck_en), .io_phase(io_phase), .io_lane(io_lane),
    .io_nibble_strobe(io_nibble_strobe), .io_phase_last(io_phase_last), .io_err(io_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Lane code: 2 = x4, 1 = x2, 0 = x1
  function automatic int lane_of(input logic spi, input logic dpi);
    if (spi) return 2;
    if (dpi) return 1;
    return 0;
  endfunction

  function automatic int cpn_of(input int lane);
    if (lane == 2) return 1;
    if (lane == 1) return 2;
    return 4;
  endfunction

  task automatic clear_req();
    io_start_signal = 0; io_stall = 0;
    io_addr_valid = 0; io_dummy_valid = 0; io_wr_valid = 0; io_rd_valid = 0; io_erase_valid = 0;
    io_inst_size = 0; io_inst_burstlen = 0; io_addr_size = 0; io_addr_burstlen = 0;
    io_dummy_size = 0; io_dummy_burstlen = 0; io_data_size = 0; io_data_burstlen = 0;
    io_addr_mode_en = 0; io_addr_spi_mode = 0; io_addr_dpi_mode = 0;
    io_data_mode_en = 0; io_data_spi_mode = 0; io_data_dpi_mode = 0;
    io_tran_spi_mode = 0; io_tran_dpi_mode = 0;
  endtask

  task automatic rand_req();
    io_addr_valid = 1'($urandom); io_dummy_valid = 1'($urandom);
    io_wr_valid = 1'($urandom); io_rd_valid = 1'($urandom);
    io_erase_valid = ($urandom_range(0, 5) == 0);
    io_inst_size = 8'($urandom_range(0, 2)); io_inst_burstlen = 8'($urandom_range(0, 2));
    io_addr_size = 8'($urandom_range(0, 6)); io_addr_burstlen = 8'($urandom_range(0, 2));
    io_dummy_size = 8'($urandom_range(0, 6)); io_dummy_burstlen = 8'($urandom_range(0, 2));
    io_data_size = 8'($urandom_range(0, 4)); io_data_burstlen = 8'($urandom_range(0, 3));
    io_addr_mode_en = 1'($urandom); io_addr_spi_mode = 1'($urandom); io_addr_dpi_mode = 1'($urandom);
    io_data_mode_en = 1'($urandom); io_data_spi_mode = 1'($urandom); io_data_dpi_mode = 1'($urandom);
    io_tran_spi_mode = 1'($urandom); io_tran_dpi_mode = 1'($urandom);
  endtask

  // Runs the request on the head fields to completion (GAP then IDLE) and checks it against the model.
  // Entered and left at posedge+1; io_stall is raised once tot==stall_at SCKs have elapsed.
  task automatic run_req(input string tag, input int stall_at, input int stall_len);
    int len[6];
    int lane[6];
    int sck[6];
    int gl, al, dl, e_tot, e_strobe, e_nph, e_err, e_stall;
    int tot, lane_bad, cs_bad, strobes, lasts, pops, errs, stalls, gaps, prev, p;
    logic [14:0] e_seq, o_seq;
    bit done;
    gl = lane_of(io_tran_spi_mode, io_tran_dpi_mode);
    al = io_addr_mode_en ? lane_of(io_addr_spi_mode, io_addr_dpi_mode) : gl;
    dl = io_data_mode_en ? lane_of(io_data_spi_mode, io_data_dpi_mode) : gl;
    lane[0] = 0; lane[1] = gl; lane[2] = al; lane[3] = gl; lane[4] = dl; lane[5] = dl;
    len[0] = 0;
    len[1] = int'(io_inst_size) * int'(io_inst_burstlen) * cpn_of(gl);
    len[2] = io_addr_valid ? int'(io_addr_size) * int'(io_addr_burstlen) * cpn_of(al) : 0;
    len[3] = (io_dummy_valid && !io_erase_valid) ?
             int'(io_dummy_size) * int'(io_dummy_burstlen) * cpn_of(gl) : 0;
    len[4] = (io_wr_valid && !io_erase_valid) ?
             int'(io_data_size) * int'(io_data_burstlen) * cpn_of(dl) : 0;
    len[5] = (io_rd_valid && !io_wr_valid && !io_erase_valid) ?
             int'(io_data_size) * int'(io_data_burstlen) * cpn_of(dl) : 0;
    e_err = ((io_wr_valid && io_rd_valid) || (io_erase_valid && (io_wr_valid || io_rd_valid))) ? 1 : 0;
    e_seq = '0; e_tot = 0; e_strobe = 0; e_nph = 0;
    for (int i = 1; i <= 5; i++) begin
      if (len[i] > 0) begin
        e_seq = (e_seq << 3) | 15'(i);
        e_tot += len[i];
        e_nph++;
        if (i != 3) e_strobe += len[i] / cpn_of(lane[i]);
      end
    end
    e_stall = (stall_at < e_tot) ? stall_len : 0;

    for (int i = 0; i < 6; i++) sck[i] = 0;
    tot = 0; lane_bad = 0; cs_bad = 0; strobes = 0; lasts = 0; pops = 0; errs = 0;
    stalls = 0; gaps = 0; prev = 0; o_seq = '0; done = 0;
    io_start_signal = 1;
    for (int c = 0; c < 4000 && !done; c++) begin
      if (pops > 0) io_start_signal = 0;
      io_stall = (io_phase >= 3'd1) && (io_phase <= 3'd5) && (tot == stall_at) && (stalls < stall_len);
      #1;
      p = int'(io_phase);
      if (p >= 1 && p <= 5) begin
        if (p != prev) o_seq = (o_seq << 3) | 15'(p);
        if (int'(io_lane) != lane[p]) lane_bad++;
        if (io_cs_n !== 1'b0) cs_bad++;
        if (io_sck_en) begin sck[p]++; tot++; end
        else stalls++;
        if (io_sck_en && io_phase_last) lasts++;
        if (io_nibble_strobe) strobes++;
      end
      if (p == 6 && io_cs_n) gaps++;
      prev = p;
      if (io_next_req) pops++;
      if (io_err) errs++;
      if (pops > 0 && p == 0) done = 1;
      @(posedge clock); #1;
    end
    io_stall = 0;
    io_start_signal = 0;

    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " seq"}, 64'(o_seq), 64'(e_seq));
    for (int i = 1; i <= 5; i++) check($sformatf("%s sck_ph%0d", tag, i), 64'(sck[i]), 64'(len[i]));
    check({tag, " lane"}, 64'(lane_bad), 64'd0);
    check({tag, " cs_low"}, 64'(cs_bad), 64'd0);
    check({tag, " strobes"}, 64'(strobes), 64'(e_strobe));
    check({tag, " lasts"}, 64'(lasts), 64'(e_nph));
    check({tag, " pops"}, 64'(pops), 64'd1);
    check({tag, " errs"}, 64'(errs), 64'(e_err));
    check({tag, " stalls"}, 64'(stalls), 64'(e_stall));
    check({tag, " gap"}, 64'(gaps), 64'(CS_GAP));
  endtask

  initial begin
    int pops, gapc, tot, found;
    bit seen_low, gap_done, done;

    // Reset state
    clear_req();
    reset = 1;
    repeat (2) @(posedge clock);
    #2;
    check("reset outs", 64'({io_cs_n, io_sck_en, io_phase, io_lane, io_nibble_strobe, io_phase_last,
                             io_next_req, io_err}), 64'({1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
    reset = 0;
    @(posedge clock); #1;

    // x1 read: INST 8, ADDR 24, RDATA 16
    clear_req();
    io_inst_size = 8'd2; io_inst_burstlen = 8'd1;
    io_addr_valid = 1; io_addr_size = 8'd6; io_addr_burstlen = 8'd1;
    io_rd_valid = 1; io_data_size = 8'd1; io_data_burstlen = 8'd4;
    run_req("x1_read", 1000, 0);

    // Quad fast read: INST 2, ADDR 6, DUMMY 6, RDATA 8, lane x4 everywhere
    clear_req();
    io_tran_spi_mode = 1;
    io_inst_size = 8'd2; io_inst_burstlen = 8'd1;
    io_addr_valid = 1; io_addr_size = 8'd6; io_addr_burstlen = 8'd1;
    io_dummy_valid = 1; io_dummy_size = 8'd6; io_dummy_burstlen = 8'd1;
    io_rd_valid = 1; io_data_size = 8'd4; io_data_burstlen = 8'd2;
    run_req("quad_read", 1000, 0);

    // x1 write of 8 SCK, 3-clock stall mid-data
    clear_req();
    io_wr_valid = 1; io_data_size = 8'd2; io_data_burstlen = 8'd1;
    run_req("wr_stall", 4, 3);

    // Back-to-back inst-only requests: CS high exactly CS_GAP clocks between them
    clear_req();
    io_inst_size = 8'd2; io_inst_burstlen = 8'd1;
    io_start_signal = 1;
    pops = 0; gapc = 0; tot = 0; seen_low = 0; gap_done = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (pops == 2) io_start_signal = 0;
      #1;
      if (io_sck_en) tot++;
      if (io_next_req) pops++;
      if (!io_cs_n) begin
        if (seen_low && gapc > 0) gap_done = 1;
        seen_low = 1;
      end else if (seen_low && !gap_done) gapc++;
      if (pops == 2 && io_phase == 3'd0) done = 1;
      @(posedge clock); #1;
    end
    io_start_signal = 0;
    check("b2b done", 64'(done), 64'd1);
    check("b2b pops", 64'(pops), 64'd2);
    check("b2b cs_gap", 64'(gapc), 64'(CS_GAP));
    check("b2b sck", 64'(tot), 64'd16);

    // Illegal wr&rd: WDATA only with one io_err pulse (x2 global)
    clear_req();
    io_tran_dpi_mode = 1;
    io_inst_size = 8'd2; io_inst_burstlen = 8'd1;
    io_wr_valid = 1; io_rd_valid = 1; io_data_size = 8'd3; io_data_burstlen = 8'd1;
    run_req("wr_rd_illegal", 1000, 0);

    // Erase with data and dummy requested: INST+ADDR only, io_err
    clear_req();
    io_erase_valid = 1; io_inst_size = 8'd2; io_inst_burstlen = 8'd1;
    io_addr_valid = 1; io_addr_size = 8'd6; io_addr_burstlen = 8'd1;
    io_dummy_valid = 1; io_dummy_size = 8'd2; io_dummy_burstlen = 8'd1;
    io_wr_valid = 1; io_data_size = 8'd2; io_data_burstlen = 8'd1;
    run_req("erase", 1000, 0);

    // Reset asserted during ADDR: back to IDLE, CS released, no pop
    clear_req();
    io_inst_size = 8'd2; io_inst_burstlen = 8'd1;
    io_addr_valid = 1; io_addr_size = 8'd6; io_addr_burstlen = 8'd1;
    io_rd_valid = 1; io_data_size = 8'd1; io_data_burstlen = 8'd1;
    io_start_signal = 1;
    pops = 0; found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      #1;
      if (io_next_req) pops++;
      if (io_phase == 3'd2) found = 1;
      else begin @(posedge clock); #1; end
    end
    reset = 1;
    @(posedge clock); #1;
    reset = 0; io_start_signal = 0;
    #1;
    if (io_next_req) pops++;
    check("rst_addr found", 64'(found), 64'd1);
    check("rst_addr phase", 64'(io_phase), 64'd0);
    check("rst_addr cs_n", 64'(io_cs_n), 64'd1);
    check("rst_addr pops", 64'(pops), 64'd0);
    @(posedge clock); #1;

`ifdef QSPI_SEQ_TIMEOUT_EN
    // Held stall aborts on the 16th stalled clock, then GAP with a pop
    clear_req();
    io_inst_size = 8'd4; io_inst_burstlen = 8'd1;
    io_start_signal = 1;
    pops = 0; tot = 0; found = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (pops > 0) io_start_signal = 0;
      io_stall = (io_phase >= 3'd1) && (io_phase <= 3'd5);
      #1;
      if (io_phase >= 3'd1 && io_phase <= 3'd5 && !io_sck_en) tot++;
      if (io_err && found == 0) found = tot;
      if (io_next_req) pops++;
      if (pops > 0 && io_phase == 3'd0) done = 1;
      @(posedge clock); #1;
    end
    io_stall = 0; io_start_signal = 0;
    check("timeout done", 64'(done), 64'd1);
    check("timeout err_at", 64'(found), 64'd16);
    check("timeout pops", 64'(pops), 64'd1);
`else
    // Without the watchdog a long stall never aborts
    clear_req();
    io_inst_size = 8'd2; io_inst_burstlen = 8'd1;
    io_rd_valid = 1; io_data_size = 8'd1; io_data_burstlen = 8'd1;
    run_req("long_stall", 3, 1100);
`endif

    // Randomized requests
    for (int r = 0; r < 24; r++) begin
      clear_req();
      rand_req();
      run_req($sformatf("rand%0d", r), int'($urandom_range(0, 20)), int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
